// File: rtl/rv_multicycle_ctrl.sv
// -----------------------------------------------------------------------------
// rv_multicycle_ctrl
// Multi-cycle control FSM for an RV32I core. Steps each instruction through
// FETCH, DECODE, EXEC, MEM and WB over a single shared memory port and drives
// the datapath controls (sign-extender format, ALU operand/op select, result
// select, register-file write, PC/IR write enables).
//
// Optional feature macro: ILLEGAL_TRAP_EN
//   defined   : an unrecognised opcode in DECODE enters TRAP and stays there
//               until reset; output illegal_instr is high while in TRAP.
//   undefined : an unrecognised opcode retires as a NOP straight from DECODE.
//
// Parameters
//   FETCH_TIMEOUT : mem_ready wait cycles allowed in FETCH/MEM before a
//                   bus_err pulse; 0 disables the check.
//
// Ports
//   clk, reset     : rising-edge clock, asynchronous active-high reset
//   instr          : instruction register contents (valid from DECODE on)
//   mem_ready      : memory completes the current request this cycle
//   branch_taken   : ALU compare result, used in EXEC for branches
//   mem_req/mem_we : memory request / store strobe
//   addr_src       : memory address select (0 PC, 1 ALU result)
//   ir_write       : load IR from memory read data
//   pc_write/pc_src: PC update enable / source (00 PC+4, 01 PC+imm, 10 ALU&~1)
//   sx_type        : sign-extender format (000 I, 001 S, 010 B, 011 U, 100 J)
//   alu_src_b      : ALU operand B select (0 rs2, 1 immediate)
//   alu_op         : 00 add, 01 compare, 10 funct3/funct7 decoded
//   result_src     : write-back select (00 ALU, 01 mem, 10 PC+4, 11 imm)
//   reg_write      : register-file write enable
//   instr_retired  : one-cycle pulse in an instruction's final cycle
//   bus_err        : one-cycle pulse on mem_ready timeout
//   state          : current FSM state encoding, for debug
//   illegal_instr  : (ILLEGAL_TRAP_EN only) high while in TRAP
// -----------------------------------------------------------------------------
module rv_multicycle_ctrl #(
    parameter int FETCH_TIMEOUT = 16
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [31:0] instr,
    input  logic        mem_ready,
    input  logic        branch_taken,
    output logic        mem_req,
    output logic        mem_we,
    output logic        addr_src,
    output logic        ir_write,
    output logic        pc_write,
    output logic [1:0]  pc_src,
    output logic [2:0]  sx_type,
    output logic        alu_src_b,
    output logic [1:0]  alu_op,
    output logic [1:0]  result_src,
    output logic        reg_write,
    output logic        instr_retired,
    output logic        bus_err,
    output logic [2:0]  state
`ifdef ILLEGAL_TRAP_EN
    ,
    output logic        illegal_instr
`endif
);

    typedef enum logic [2:0] {
        S_FETCH  = 3'd0,
        S_DECODE = 3'd1,
        S_EXEC   = 3'd2,
        S_MEM    = 3'd3,
        S_WB     = 3'd4,
        S_TRAP   = 3'd5
    } state_e;

    localparam logic [6:0] OP_LOAD   = 7'b0000011;
    localparam logic [6:0] OP_IMM    = 7'b0010011;
    localparam logic [6:0] OP_AUIPC  = 7'b0010111;
    localparam logic [6:0] OP_STORE  = 7'b0100011;
    localparam logic [6:0] OP_REG    = 7'b0110011;
    localparam logic [6:0] OP_LUI    = 7'b0110111;
    localparam logic [6:0] OP_BRANCH = 7'b1100011;
    localparam logic [6:0] OP_JALR   = 7'b1100111;
    localparam logic [6:0] OP_JAL    = 7'b1101111;

    localparam logic [2:0] SX_I = 3'b000;
    localparam logic [2:0] SX_S = 3'b001;
    localparam logic [2:0] SX_B = 3'b010;
    localparam logic [2:0] SX_U = 3'b011;
    localparam logic [2:0] SX_J = 3'b100;

    // Counter wide enough to hold FETCH_TIMEOUT itself.
    localparam int CNT_W = (FETCH_TIMEOUT > 0) ? $clog2(FETCH_TIMEOUT + 1) : 1;
    localparam logic [CNT_W-1:0] TIMEOUT_C  = CNT_W'(FETCH_TIMEOUT);
    localparam bit               TIMEOUT_EN = (FETCH_TIMEOUT != 0);

    state_e           state_r;
    state_e           state_next_s;
    logic [2:0]       sx_type_r;
    logic [2:0]       sx_next_s;
    logic [CNT_W-1:0] wait_cnt_r;
    logic [CNT_W-1:0] wait_cnt_next_s;
    logic [6:0]       opcode_s;
    logic [4:0]       rd_s;
    logic             legal_s;
    logic             waiting_s;
    logic             timeout_hit_s;
    logic             unused_instr_s;

    assign opcode_s = instr[6:0];
    assign rd_s     = instr[11:7];

    // The upper instruction fields are decoded by the datapath, not here.
    assign unused_instr_s = ^instr[31:12];

    assign sx_type = sx_type_r;
    assign state   = state_r;

`ifdef ILLEGAL_TRAP_EN
    assign illegal_instr = (state_r == S_TRAP);
`endif

    // Opcode legality check used in DECODE.
    always_comb begin
        case (opcode_s)
            OP_LOAD, OP_IMM, OP_AUIPC, OP_STORE, OP_REG,
            OP_LUI, OP_BRANCH, OP_JALR, OP_JAL: legal_s = 1'b1;
            default:                            legal_s = 1'b0;
        endcase
    end

    // A memory wait cycle is one spent in FETCH/MEM without mem_ready; the
    // timeout fires on the wait cycle where the count has reached the limit.
    assign waiting_s     = ((state_r == S_FETCH) || (state_r == S_MEM)) && !mem_ready;
    assign timeout_hit_s = TIMEOUT_EN && waiting_s && (wait_cnt_r == TIMEOUT_C);

    // Next-state and datapath control decode.
    always_comb begin
        state_next_s  = state_r;
        mem_req       = 1'b0;
        mem_we        = 1'b0;
        addr_src      = 1'b0;
        ir_write      = 1'b0;
        pc_write      = 1'b0;
        pc_src        = 2'b00;
        alu_src_b     = 1'b0;
        alu_op        = 2'b00;
        result_src    = 2'b00;
        reg_write     = 1'b0;
        instr_retired = 1'b0;
        bus_err       = 1'b0;

        case (state_r)
            S_FETCH: begin
                mem_req  = 1'b1;
                addr_src = 1'b0;
                if (mem_ready) begin
                    ir_write     = 1'b1;
                    pc_write     = 1'b1;
                    pc_src       = 2'b00;
                    state_next_s = S_DECODE;
                end else if (timeout_hit_s) begin
                    bus_err      = 1'b1;
                    state_next_s = S_FETCH;
                end else begin
                    state_next_s = S_FETCH;
                end
            end

            S_DECODE: begin
                if (legal_s) begin
                    state_next_s = S_EXEC;
                end else begin
`ifdef ILLEGAL_TRAP_EN
                    state_next_s = S_TRAP;
`else
                    // PC already advanced in FETCH, so this is a plain NOP.
                    instr_retired = 1'b1;
                    state_next_s  = S_FETCH;
`endif
                end
            end

            S_EXEC: begin
                case (opcode_s)
                    OP_REG: begin
                        alu_src_b    = 1'b0;
                        alu_op       = 2'b10;
                        state_next_s = S_WB;
                    end
                    OP_IMM: begin
                        alu_src_b    = 1'b1;
                        alu_op       = 2'b10;
                        state_next_s = S_WB;
                    end
                    OP_LOAD, OP_STORE: begin
                        alu_src_b    = 1'b1;
                        alu_op       = 2'b00;
                        state_next_s = S_MEM;
                    end
                    OP_AUIPC: begin
                        alu_src_b    = 1'b1;
                        alu_op       = 2'b00;
                        state_next_s = S_WB;
                    end
                    OP_JALR: begin
                        alu_src_b    = 1'b1;
                        alu_op       = 2'b00;
                        pc_write     = 1'b1;
                        pc_src       = 2'b10;
                        state_next_s = S_WB;
                    end
                    OP_BRANCH: begin
                        alu_op        = 2'b01;
                        pc_write      = branch_taken;
                        pc_src        = 2'b01;
                        instr_retired = 1'b1;
                        state_next_s  = S_FETCH;
                    end
                    OP_JAL: begin
                        pc_write     = 1'b1;
                        pc_src       = 2'b01;
                        state_next_s = S_WB;
                    end
                    OP_LUI: begin
                        state_next_s = S_WB;
                    end
                    default: begin
                        state_next_s = S_FETCH;
                    end
                endcase
            end

            S_MEM: begin
                mem_req  = 1'b1;
                addr_src = 1'b1;
                mem_we   = (opcode_s == OP_STORE);
                if (mem_ready) begin
                    if (opcode_s == OP_STORE) begin
                        instr_retired = 1'b1;
                        state_next_s  = S_FETCH;
                    end else begin
                        state_next_s = S_WB;
                    end
                end else if (timeout_hit_s) begin
                    bus_err      = 1'b1;
                    state_next_s = S_FETCH;
                end else begin
                    state_next_s = S_MEM;
                end
            end

            S_WB: begin
                reg_write = (rd_s != 5'd0);
                case (opcode_s)
                    OP_LOAD:         result_src = 2'b01;
                    OP_JAL, OP_JALR: result_src = 2'b10;
                    OP_LUI:          result_src = 2'b11;
                    default:         result_src = 2'b00;
                endcase
                instr_retired = 1'b1;
                state_next_s  = S_FETCH;
            end

            S_TRAP: begin
`ifdef ILLEGAL_TRAP_EN
                state_next_s = S_TRAP;
`else
                state_next_s = S_FETCH;
`endif
            end

            default: begin
                state_next_s = S_FETCH;
            end
        endcase
    end

    // Sign-extender format is captured in DECODE; R-type and unknown opcodes
    // keep the previous format.
    always_comb begin
        sx_next_s = sx_type_r;
        if (state_r == S_DECODE) begin
            case (opcode_s)
                OP_LOAD, OP_IMM, OP_JALR: sx_next_s = SX_I;
                OP_STORE:                 sx_next_s = SX_S;
                OP_BRANCH:                sx_next_s = SX_B;
                OP_LUI, OP_AUIPC:         sx_next_s = SX_U;
                OP_JAL:                   sx_next_s = SX_J;
                default:                  sx_next_s = sx_type_r;
            endcase
        end else begin
            sx_next_s = sx_type_r;
        end
    end

    // Wait counter restarts on every state change, including a timeout
    // re-entry into FETCH, and only counts wait cycles.
    always_comb begin
        wait_cnt_next_s = '0;
        if ((state_next_s != state_r) || timeout_hit_s) begin
            wait_cnt_next_s = '0;
        end else if (waiting_s && TIMEOUT_EN) begin
            wait_cnt_next_s = wait_cnt_r + CNT_W'(1);
        end else begin
            wait_cnt_next_s = '0;
        end
    end

    // State, sign-extender format and wait counter registers.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_r    <= S_FETCH;
            sx_type_r  <= SX_I;
            wait_cnt_r <= '0;
        end else begin
            state_r    <= state_next_s;
            sx_type_r  <= sx_next_s;
            wait_cnt_r <= wait_cnt_next_s;
        end
    end

endmodule

// File: doc/rv_multicycle_ctrl.md
Name: rv_multicycle_ctrl

Overview:
- Multi-cycle control FSM for the RV32I core.
- Sequences fetch, decode, execute, memory and writeback over a shared memory port.
- Drives the sign extender's sx_type, ALU and register-file controls, and the PC/IR write enables.
- Sits between the instruction register and the datapath muxes. Holds only FSM state and registered controls.

Parameters:
- FETCH_TIMEOUT, 16, max mem_ready wait cycles in FETCH/MEM before the bus_err pulse; 0 disables the check.

Ports:
- clk  in  1  system clock, rising edge
- reset  in  1  asynchronous, active-high reset
- instr  in  32  instruction register contents, valid from DECODE onward
- mem_ready  in  1  memory completes the current request this cycle
- branch_taken  in  1  ALU compare result, sampled in EXEC for branches
- mem_req  out  1  memory request (fetch or data)
- mem_we  out  1  store strobe, qualified by mem_req
- addr_src  out  1  0 = PC, 1 = ALU result
- ir_write  out  1  load IR from memory read data
- pc_write  out  1  update PC
- pc_src  out  2  00 PC+4, 01 PC+imm, 10 ALU result with bit0 cleared
- sx_type  out  3  sign-extender format: 000 I, 001 S, 010 B, 011 U, 100 J
- alu_src_b  out  1  0 = rs2, 1 = immediate
- alu_op  out  2  00 add, 01 compare (funct3), 10 funct3/funct7 decoded
- result_src  out  2  00 ALU, 01 memory data, 10 PC+4, 11 immediate
- reg_write  out  1  register-file write enable
- instr_retired  out  1  one-cycle pulse when an instruction completes
- bus_err  out  1  one-cycle pulse on mem_ready timeout
- state  out  3  current state encoding, for debug

Behaviour:
- Reset: state = FETCH; all outputs 0 except the combinational mem_req, which is 1 in FETCH.
- Reset asserted mid-request abandons the request immediately.
- State encodings: FETCH=0, DECODE=1, EXEC=2, MEM=3, WB=4, TRAP=5.
- FETCH:
  - mem_req=1, addr_src=0.
  - On mem_ready: ir_write=1, pc_write=1, pc_src=00, then go to DECODE.
  - Otherwise stay in FETCH.
- DECODE (1 cycle):
  - sx_type is registered from instr[6:0]:
    - LOAD/OP-IMM/JALR → I
    - STORE → S
    - BRANCH → B
    - LUI/AUIPC → U
    - JAL → J
    - R-type and illegal opcodes → hold the previous value
  - sx_type stays stable until the next DECODE.
  - Go to EXEC.
- EXEC:
  - R-type: alu_src_b=0, alu_op=10.
  - OP-IMM: alu_src_b=1, alu_op=10.
  - LOAD/STORE/JALR/AUIPC: alu_src_b=1, alu_op=00.
  - BRANCH:
    - alu_op=01; pc_write=branch_taken, pc_src=01.
    - Retire and go to FETCH.
  - JAL: pc_write=1, pc_src=01, then go to WB.
  - JALR: pc_write=1, pc_src=10, then go to WB.
  - LOAD/STORE go to MEM; all others go to WB.
- MEM:
  - mem_req=1, addr_src=1, mem_we=1 for STORE.
  - Wait for mem_ready.
  - LOAD goes to WB.
  - STORE retires and goes to FETCH.
- WB:
  - reg_write=1, suppressed when rd = instr[11:7] = 0.
  - result_src: 01 LOAD, 10 JAL/JALR, 11 LUI, 00 otherwise.
  - Retire and go to FETCH.
- instr_retired asserts in the final state's cycle.
- Latency with zero-wait memory (mem_ready=1 on request):
  - branch: 3 cycles
  - R-type / I-type / store / jump: 4 cycles
  - load: 5 cycles
- mem_ready outside FETCH/MEM is ignored.
- Wait counter:
  - Resets on entry to FETCH/MEM.
  - When FETCH_TIMEOUT ≠ 0 and the count reaches FETCH_TIMEOUT, bus_err pulses for one cycle and the FSM goes to FETCH.
  - The PC is not updated.
- All non-listed outputs are 0 in every state.

Optional Feature:
- ILLEGAL_TRAP_EN defined: an unrecognised opcode in DECODE transitions to TRAP.
  - TRAP holds, with all enables 0 and no retire, until reset.
  - The added output illegal_instr (1 bit) is high while in TRAP.
- ILLEGAL_TRAP_EN undefined: an unrecognised opcode is treated as a NOP.
  - DECODE → FETCH with instr_retired=1.
  - The PC was already advanced in FETCH.
  - No illegal_instr port exists.

Test Plan:
- Reset release, mem_ready=1, instr=32'h00500093 (addi x1,x0,5) → state 0,1,2,4,0; sx_type=000; alu_src_b=1 in EXEC; reg_write=1 and instr_retired=1 in WB.
- instr=32'h0020a423 (sw), mem_ready low 3 cycles in MEM → mem_req=mem_we=addr_src=1 held 4 cycles; sx_type=001; no reg_write; retire on the ready cycle.
- instr=32'h00208463 (beq): branch_taken=1 → pc_write=1 with pc_src=01 in EXEC, 3-cycle instruction; branch_taken=0 → pc_write=0.
- instr=32'h008000ef (jal x1) → sx_type=100; pc_src=01 in EXEC; result_src=10 and reg_write=1 in WB. instr=32'h00000013 (addi with rd=0) → reg_write stays 0.
- FETCH_TIMEOUT=4, mem_ready held 0 → bus_err pulses after 4 wait cycles; FSM re-enters FETCH; pc_write never asserted.
- instr=32'hFFFFFFFF → with ILLEGAL_TRAP_EN: state=5, illegal_instr=1 until reset asserted mid-TRAP (then FETCH). Without it: returns to FETCH with instr_retired pulse.
